// File: rtl/can_pkg.sv
// Shared CAN receive-path definitions: destuffer state encoding, bus level
// constants and the default stuff run length.
package can_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    STUFFING   = 3'd1,
    STUFF_TAIL = 3'd2,
    PASS       = 3'd3,
    ERROR      = 3'd4
  } destuff_state_e;

  localparam logic CAN_DOMINANT  = 1'b0;
  localparam logic CAN_RECESSIVE = 1'b1;

  localparam int CAN_STUFF_LIMIT = 5;

endpackage

// File: rtl/can_bit_destuffer.sv
// CAN receive bit destuffer. Drops the stuff bit that follows every run of
// STUFF_LIMIT equal bits, forwards everything else, and flags a stuff error
// when the run is not broken. After the frame decoder signals the end of the
// stuffed region, a pending stuff bit is checked and then samples pass through.
// Optional: define CAN_DESTUFF_COUNT_EN to add the per-frame stuff_count port.
module can_bit_destuffer
  import can_pkg::*;
#(
  parameter int STUFF_LIMIT = CAN_STUFF_LIMIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       sample_point,
  input  logic       rx_bit,
  input  logic       stuff_region_end,
  input  logic       frame_end,
  output logic       destuffed_bit,
  output logic       destuffed_valid,
  output logic       stuff_bit_removed,
  output logic       stuff_error,
  output logic       stuff_error_flag,
  output logic [2:0] consecutive_count,
  output logic       destuffing_active
`ifdef CAN_DESTUFF_COUNT_EN
  ,
  output logic [7:0] stuff_count
`endif
);

  localparam logic [2:0] LIMIT_C = 3'(STUFF_LIMIT);

  destuff_state_e state_q, state_d;
  logic       last_q, last_d;
  logic [2:0] count_q, count_d;
  logic       bit_q, bit_d;
  logic       valid_q, valid_d;
  logic       removed_q, removed_d;
  logic       err_q, err_d;
  logic       flag_q, flag_d;

  // Next-state, run-length tracking and output pulse generation
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    count_d   = count_q;
    bit_d     = bit_q;
    valid_d   = 1'b0;
    removed_d = 1'b0;
    err_d     = 1'b0;
    flag_d    = flag_q;

    if (!enable || frame_end) begin
      state_d = IDLE;
      count_d = 3'd0;
      flag_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sample_point && rx_bit == CAN_DOMINANT) begin
            valid_d = 1'b1;
            bit_d   = CAN_DOMINANT;
            last_d  = CAN_DOMINANT;
            count_d = 3'd1;
            state_d = STUFFING;
          end
        end
        STUFFING: begin
          if (sample_point) begin
            if (count_q == LIMIT_C) begin
              if (rx_bit != last_q) begin
                removed_d = 1'b1;
                last_d    = rx_bit;
                count_d   = 3'd1;
              end else begin
                err_d   = 1'b1;
                flag_d  = 1'b1;
                state_d = ERROR;
              end
            end else begin
              valid_d = 1'b1;
              bit_d   = rx_bit;
              last_d  = rx_bit;
              count_d = (rx_bit == last_q) ? count_q + 3'd1 : 3'd1;
            end
          end
          // A same-cycle sample is already folded into count_d here
          if (stuff_region_end && state_d != ERROR) begin
            if (count_d == LIMIT_C) begin
              state_d = STUFF_TAIL;
            end else begin
              state_d = PASS;
              count_d = 3'd0;
            end
          end
        end
        STUFF_TAIL: begin
          if (sample_point) begin
            if (rx_bit != last_q) begin
              removed_d = 1'b1;
              last_d    = rx_bit;
              count_d   = 3'd0;
              state_d   = PASS;
            end else begin
              err_d   = 1'b1;
              flag_d  = 1'b1;
              state_d = ERROR;
            end
          end
        end
        PASS: begin
          count_d = 3'd0;
          if (sample_point) begin
            valid_d = 1'b1;
            bit_d   = rx_bit;
            last_d  = rx_bit;
          end
        end
        ERROR: begin
        end
        default: begin
          state_d = IDLE;
          count_d = 3'd0;
        end
      endcase
    end
  end

  // State and output registers; reset aborts any frame in progress
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= CAN_RECESSIVE;
      count_q   <= 3'd0;
      bit_q     <= CAN_RECESSIVE;
      valid_q   <= 1'b0;
      removed_q <= 1'b0;
      err_q     <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      count_q   <= count_d;
      bit_q     <= bit_d;
      valid_q   <= valid_d;
      removed_q <= removed_d;
      err_q     <= err_d;
      flag_q    <= flag_d;
    end
  end

  assign destuffed_bit     = bit_q;
  assign destuffed_valid   = valid_q;
  assign stuff_bit_removed = removed_q;
  assign stuff_error       = err_q;
  assign stuff_error_flag  = flag_q;
  assign consecutive_count = count_q;
  assign destuffing_active = (state_q == STUFFING) || (state_q == STUFF_TAIL);

`ifdef CAN_DESTUFF_COUNT_EN
  logic [7:0] stuff_count_q, stuff_count_d;

  // Per-frame stuff bit counter: cleared on SOF, saturates at 255
  always_comb begin
    stuff_count_d = stuff_count_q;
    if (enable && !frame_end && state_q == IDLE && sample_point &&
        rx_bit == CAN_DOMINANT) begin
      stuff_count_d = 8'd0;
    end else if (removed_d && stuff_count_q != 8'hFF) begin
      stuff_count_d = stuff_count_q + 8'd1;
    end
  end

  // Stuff counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stuff_count_q <= 8'd0;
    end else begin
      stuff_count_q <= stuff_count_d;
    end
  end

  assign stuff_count = stuff_count_q;
`endif

endmodule
